// File: rtl/lu_repair_scheduler_pkg.sv
// Shared types and constants for the logic-unit repair scheduler.
// Holds the FSM state enum, the unit function encodings and the last sweep vector index.
package lu_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOST    = 2'd1,
      ST_T_APPLY = 2'd2,
      ST_T_CHECK = 2'd3
   } sched_state_e;

   localparam logic [1:0] LU_AND  = 2'd0;
   localparam logic [1:0] LU_OR   = 2'd1;
   localparam logic [1:0] LU_XOR  = 2'd2;
   localparam logic [1:0] LU_NAND = 2'd3;

   localparam logic [5:0] VEC_LAST = 6'd63;

endpackage

// File: rtl/lu_repair_scheduler_if.sv
// Host evaluation handshake between the SPI command decoder and the scheduler.
// The master is the decoder side; the slave is the scheduler.
interface lu_repair_scheduler_if;
   logic       host_req;
   logic [1:0] host_func;
   logic [1:0] host_a;
   logic [1:0] host_b;
   logic       host_gnt;
   logic [1:0] host_result;

   modport master (
      output host_req, host_func, host_a, host_b,
      input  host_gnt, host_result
   );

   modport slave (
      input  host_req, host_func, host_a, host_b,
      output host_gnt, host_result
   );
endinterface

// File: rtl/lu_repair_scheduler_golden.sv
// Reference 2-bit logic unit used to judge the self-test responses.
// Purely combinational; mirrors the function encoding in lu_sched_pkg.
module lu_golden
   import lu_sched_pkg::*;
(
   input  logic [1:0] func_i,
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic [1:0] result_o
);

   always_comb begin
      result_o = 2'b00;
      case (func_i)
         LU_AND:  result_o = a_i & b_i;
         LU_OR:   result_o = a_i | b_i;
         LU_XOR:  result_o = a_i ^ b_i;
         LU_NAND: result_o = ~(a_i & b_i);
         default: result_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/lu_repair_scheduler.sv
// Shares the primary/spare logic unit between host requests and a periodic 64-vector self-test,
// switching to the spare after repeated failing sweeps. Optional macro: LU_FAULT_INJECT_EN.
//
// state      | meaning
// ST_IDLE    | waiting; host request wins over a queued sweep
// ST_HOST    | host operands on the bus; second phase registers result and grants
// ST_T_APPLY | drive sweep vector vec onto the units
// ST_T_CHECK | compare selected unit against golden, advance or end the sweep
module lu_repair_scheduler
   import lu_sched_pkg::*;
#(
   parameter int unsigned TEST_PERIOD = 12_500_000,
   parameter int unsigned FAIL_LIMIT  = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   lu_repair_scheduler_if.slave   host,
   output logic [1:0]             lu_func,
   output logic [1:0]             lu_a,
   output logic [1:0]             lu_b,
   input  logic [1:0]             lu_result_main,
   input  logic [1:0]             lu_result_spare,
`ifdef LU_FAULT_INJECT_EN
   input  logic                   inject_fault,
`endif
   output logic                   use_spare,
   output logic                   error_flag,
   output logic                   fatal,
   output logic                   test_busy
);

   localparam int unsigned   TW         = (TEST_PERIOD > 1) ? $clog2(TEST_PERIOD) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TEST_PERIOD - 1);
   localparam logic [3:0]    FAIL_LIM   = 4'(FAIL_LIMIT);

   sched_state_e  state_q, resume_q;
   logic          host_ph_q;
   logic [5:0]    vec_q;
   logic          sweep_fail_q;
   logic [3:0]    fail_cnt_q;
   logic          pending_q;
   logic [TW-1:0] timer_q;
   logic [1:0]    cap_func_q, cap_a_q, cap_b_q;
   logic [1:0]    lu_func_q, lu_a_q, lu_b_q;
   logic          host_gnt_q;
   logic [1:0]    host_result_q;
   logic          use_spare_q, error_flag_q, fatal_q, test_busy_q;

   logic [1:0]    golden_res;
   logic [1:0]    main_res;
   logic [1:0]    sel_res;
   logic          mismatch;
   logic          timer_wrap;
   logic          sweep_start;
   logic [3:0]    fail_cnt_d;
   logic          limit_hit;

   lu_golden u_golden (
      .func_i   (lu_func_q),
      .a_i      (lu_a_q),
      .b_i      (lu_b_q),
      .result_o (golden_res)
   );

   always_comb begin
      main_res = lu_result_main;
`ifdef LU_FAULT_INJECT_EN
      main_res = lu_result_main ^ {1'b0, inject_fault};
`endif
      sel_res     = use_spare_q ? lu_result_spare : main_res;
      mismatch    = (sel_res != golden_res);
      timer_wrap  = (timer_q == TIMER_LAST);
      sweep_start = (state_q == ST_IDLE) && !host.host_req && pending_q;
      // Counter outcome if this cycle closes the sweep (includes the current compare).
      if (sweep_fail_q || mismatch)
         fail_cnt_d = (fail_cnt_q == 4'd15) ? 4'd15 : fail_cnt_q + 4'd1;
      else
         fail_cnt_d = 4'd0;
      limit_hit = (fail_cnt_d >= FAIL_LIM);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         resume_q      <= ST_IDLE;
         host_ph_q     <= 1'b0;
         vec_q         <= '0;
         sweep_fail_q  <= 1'b0;
         fail_cnt_q    <= '0;
         pending_q     <= 1'b0;
         timer_q       <= '0;
         cap_func_q    <= '0;
         cap_a_q       <= '0;
         cap_b_q       <= '0;
         lu_func_q     <= '0;
         lu_a_q        <= '0;
         lu_b_q        <= '0;
         host_gnt_q    <= 1'b0;
         host_result_q <= '0;
         use_spare_q   <= 1'b0;
         error_flag_q  <= 1'b0;
         fatal_q       <= 1'b0;
         test_busy_q   <= 1'b0;
      end else begin
         host_gnt_q <= 1'b0;
         timer_q    <= timer_wrap ? '0 : timer_q + TW'(1);
         pending_q  <= timer_wrap | (pending_q & ~sweep_start);

         case (state_q)
            ST_IDLE: begin
               if (host.host_req) begin
                  cap_func_q <= host.host_func;
                  cap_a_q    <= host.host_a;
                  cap_b_q    <= host.host_b;
                  lu_func_q  <= host.host_func;
                  lu_a_q     <= host.host_a;
                  lu_b_q     <= host.host_b;
                  host_ph_q  <= 1'b1;
                  resume_q   <= ST_IDLE;
                  state_q    <= ST_HOST;
               end else if (pending_q) begin
                  vec_q        <= '0;
                  sweep_fail_q <= 1'b0;
                  test_busy_q  <= 1'b1;
                  state_q      <= ST_T_APPLY;
               end
            end

            ST_HOST: begin
               // A mid-sweep slot enters in phase 0 and spends one cycle driving the bus.
               if (!host_ph_q) begin
                  lu_func_q <= cap_func_q;
                  lu_a_q    <= cap_a_q;
                  lu_b_q    <= cap_b_q;
                  host_ph_q <= 1'b1;
               end else begin
                  host_result_q <= sel_res;
                  host_gnt_q    <= 1'b1;
                  state_q       <= resume_q;
               end
            end

            ST_T_APPLY: begin
               lu_func_q <= vec_q[5:4];
               lu_a_q    <= vec_q[3:2];
               lu_b_q    <= vec_q[1:0];
               state_q   <= ST_T_CHECK;
            end

            ST_T_CHECK: begin
               if (mismatch) begin
                  sweep_fail_q <= 1'b1;
                  error_flag_q <= 1'b1;
               end
               if (vec_q == VEC_LAST) begin
                  if (limit_hit && !use_spare_q) begin
                     use_spare_q <= 1'b1;
                     fail_cnt_q  <= 4'd0;
                  end else begin
                     fail_cnt_q <= fail_cnt_d;
                     if (limit_hit)
                        fatal_q <= 1'b1;
                  end
                  test_busy_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  vec_q <= vec_q + 6'd1;
                  if (host.host_req) begin
                     cap_func_q <= host.host_func;
                     cap_a_q    <= host.host_a;
                     cap_b_q    <= host.host_b;
                     host_ph_q  <= 1'b0;
                     resume_q   <= ST_T_APPLY;
                     state_q    <= ST_HOST;
                  end else begin
                     state_q <= ST_T_APPLY;
                  end
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign host.host_gnt    = host_gnt_q;
   assign host.host_result = host_result_q;
   assign lu_func          = lu_func_q;
   assign lu_a             = lu_a_q;
   assign lu_b             = lu_b_q;
   assign use_spare        = use_spare_q;
   assign error_flag       = error_flag_q;
   assign fatal            = fatal_q;
   assign test_busy        = test_busy_q;

endmodule

// File: tb/tb_lu_repair_scheduler.sv
// Self-checking bench for lu_repair_scheduler: host grants, healthy/faulty sweeps,
// repair to spare, fatal escalation and mid-sweep reset, against a behavioural model.
module tb_lu_repair_scheduler;

   localparam int TP = 200;
   localparam int FL = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] lu_func, lu_a, lu_b;
   logic [1:0] lu_result_main, lu_result_spare;
   logic       use_spare, error_flag, fatal, test_busy;
   logic       main_stuck = 1'b0;
   logic       spare_stuck = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model of the sticky state
   bit m_spare = 0, m_fatal = 0, m_error = 0;
   int m_cnt = 0;

   lu_repair_scheduler_if host_if ();

   lu_repair_scheduler #(.TEST_PERIOD(TP), .FAIL_LIMIT(FL)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .host            (host_if),
      .lu_func         (lu_func),
      .lu_a            (lu_a),
      .lu_b            (lu_b),
      .lu_result_main  (lu_result_main),
      .lu_result_spare (lu_result_spare),
      .use_spare       (use_spare),
      .error_flag      (error_flag),
      .fatal           (fatal),
      .test_busy       (test_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ref_lu(input logic [1:0] f, input logic [1:0] a, input logic [1:0] b);
      case (f)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   function automatic logic [1:0] unit_out(input bit spare, input logic [1:0] f, input logic [1:0] a, input logic [1:0] b);
      if (spare ? spare_stuck : main_stuck) return 2'b00;
      return ref_lu(f, a, b);
   endfunction

   assign lu_result_main  = main_stuck  ? 2'b00 : ref_lu(lu_func, lu_a, lu_b);
   assign lu_result_spare = spare_stuck ? 2'b00 : ref_lu(lu_func, lu_a, lu_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},    32'(host_if.host_gnt), 0);
      chk({tag, "_result"}, 32'(host_if.host_result), 0);
      chk({tag, "_lu"},     32'({lu_func, lu_a, lu_b}), 0);
      chk({tag, "_spare"},  32'(use_spare), 0);
      chk({tag, "_error"},  32'(error_flag), 0);
      chk({tag, "_fatal"},  32'(fatal), 0);
      chk({tag, "_busy"},   32'(test_busy), 0);
   endtask

   // Host request issued from IDLE: operands one cycle later, grant two cycles later.
   task automatic host_op(input logic [1:0] f, input logic [1:0] a, input logic [1:0] b);
      logic [1:0] exp;
      exp = unit_out(m_spare, f, a, b);
      chk("host_idle_busy", 32'(test_busy), 0);
      host_if.host_req  = 1'b1;
      host_if.host_func = f;
      host_if.host_a    = a;
      host_if.host_b    = b;
      @(negedge clk);
      chk("host_lu_drive", 32'({lu_func, lu_a, lu_b}), 32'({f, a, b}));
      chk("host_gnt_early", 32'(host_if.host_gnt), 0);
      @(negedge clk);
      chk("host_gnt", 32'(host_if.host_gnt), 1);
      chk("host_result", 32'(host_if.host_result), 32'(exp));
      host_if.host_req = 1'b0;
   endtask

   task automatic host_random(input int n);
      for (int i = 0; i < n; i++)
         host_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      @(negedge clk);
      chk("host_gnt_pulse", 32'(host_if.host_gnt), 0);
   endtask

   // Waits for the next sweep, optionally injects a host request at T_APPLY of host_vec
   // or a reset at T_APPLY of rst_vec, then checks length and sticky flags against the model.
   task automatic run_sweep(input int host_vec, input int rst_vec);
      int w, c, gnt_c, err_c, v_first, exp_err_c;
      bit sfail, rq, err_before;
      logic [1:0] hf, ha, hb, hexp;
      logic [5:0] vv;

      sfail = 0;
      v_first = -1;
      for (int v = 0; v < 64; v++) begin
         vv = v[5:0];
         if (unit_out(m_spare, vv[5:4], vv[3:2], vv[1:0]) !== ref_lu(vv[5:4], vv[3:2], vv[1:0])) begin
            if (!sfail) v_first = v;
            sfail = 1;
         end
      end
      err_before = m_error;

      w = 0;
      while (test_busy !== 1'b1 && w < 3 * TP) begin
         @(negedge clk);
         w++;
      end
      chk("sweep_start", 32'(test_busy), 1);
      if (test_busy !== 1'b1) return;

      c = 0; gnt_c = -1; err_c = -1; rq = 0; hexp = 2'b00;
      while (test_busy === 1'b1 && c < 400) begin
         if (c == 1) chk("vec0_drive", 32'({lu_func, lu_a, lu_b}), 0);
         if (host_vec >= 0 && c == 2 * host_vec + 5)
            chk("resume_vec", 32'({lu_func, lu_a, lu_b}), 32'(host_vec + 1));
         if (err_c < 0 && error_flag === 1'b1) err_c = c;
         if (rq && host_if.host_gnt === 1'b1) begin
            gnt_c = c;
            chk("sweep_host_result", 32'(host_if.host_result), 32'(hexp));
            host_if.host_req = 1'b0;
            rq = 0;
         end
         if (host_vec >= 0 && c == 2 * host_vec) begin
            hf = 2'($urandom_range(0, 3));
            ha = 2'($urandom_range(0, 3));
            hb = 2'($urandom_range(0, 3));
            hexp = unit_out(m_spare, hf, ha, hb);
            host_if.host_func = hf;
            host_if.host_a    = ha;
            host_if.host_b    = hb;
            host_if.host_req  = 1'b1;
            rq = 1;
         end
         if (rst_vec >= 0 && c == 2 * rst_vec) begin
            reset_n = 1'b0;
            #1;
            chk_all_zero("midsweep_reset");
            m_spare = 0; m_fatal = 0; m_error = 0; m_cnt = 0;
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         @(negedge clk);
         c++;
      end
      if (err_c < 0 && error_flag === 1'b1) err_c = c;
      if (rq) host_if.host_req = 1'b0;

      chk("sweep_len", 32'(c), (host_vec >= 0) ? 130 : 128);
      if (host_vec >= 0) chk("sweep_gnt_cycle", 32'(gnt_c), 32'(2 * host_vec + 4));
      if (err_before) exp_err_c = 0;
      else if (v_first < 0) exp_err_c = -1;
      else exp_err_c = 2 * v_first + 2 + ((host_vec >= 0 && v_first > host_vec) ? 2 : 0);
      chk("error_rise_cycle", 32'(err_c), 32'(exp_err_c));

      if (sfail) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
      else m_cnt = 0;
      if (m_cnt >= FL) begin
         if (!m_spare) begin
            m_spare = 1;
            m_cnt = 0;
         end else begin
            m_fatal = 1;
         end
      end
      m_error = m_error | sfail;

      chk("sweep_error_flag", 32'(error_flag), 32'(m_error));
      chk("sweep_use_spare",  32'(use_spare),  32'(m_spare));
      chk("sweep_fatal",      32'(fatal),      32'(m_fatal));
   endtask

   initial begin
      host_if.host_req  = 1'b0;
      host_if.host_func = 2'b00;
      host_if.host_a    = 2'b00;
      host_if.host_b    = 2'b00;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      @(negedge clk);

      host_op(2'd2, 2'b01, 2'b11);
      host_random(6);

      run_sweep(-1, -1);
      host_random(2);
      run_sweep(10, -1);

      main_stuck = 1'b1;
      host_random(2);
      run_sweep(-1, -1);
      run_sweep(-1, -1);
      host_random(3);
      run_sweep(-1, -1);

      spare_stuck = 1'b1;
      run_sweep(-1, -1);
      run_sweep(-1, -1);

      run_sweep(-1, 40);
      run_sweep(-1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
